// File: rtl/dmem_req_responder.sv
// dmem_req_responder: in-order data-side request responder between the EXE
// stage (req/addr_ok) and a req/ack memory backend, answering via data_ok.
// Ports: clk, reset (async, active high); EXE side req, wr, size, addr,
// wstrb, wdata, addr_ok; MEM side data_ok, rdata; backend mem_req, mem_we,
// mem_addr, mem_wstrb, mem_wdata, mem_ack, mem_rdata; perf_cnt.
// Optional: define DMEM_RESP_PERF_EN to enable the perf_cnt stall counter.
module dmem_req_responder #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          wr,
  input  logic [1:0]    size,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  output logic          addr_ok,
  output logic          data_ok,
  output logic [31:0]   rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   perf_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic          wr;
    logic [1:0]    size;
    logic [3:0]    wstrb;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } ent_t;

  typedef enum logic {
    ISSUE,
    RESP
  } state_t;

  ent_t          fifo_q [DEPTH];
  ent_t          head;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;
  state_t        state_q;
  state_t        state_d;
  logic [31:0]   rdata_q;
  logic          push;
  logic          pop;
  logic          ld_cap;
  logic          unused_bits;

  assign head    = fifo_q[rptr_q];
  assign addr_ok = (cnt_q != FULL);
  assign push    = req & addr_ok;
  assign rdata   = rdata_q;

  // size is kept with the entry for the MEM stage's benefit only;
  // the backend always sees a full aligned word.
  assign unused_bits = ^{head.size, head.addr[1:0]};

  assign mem_we    = mem_req & head.wr;
  assign mem_addr  = mem_req ? {head.addr[AW-1:2], 2'b00} : '0;
  assign mem_wstrb = (mem_req & head.wr) ? head.wstrb : 4'h0;
  assign mem_wdata = mem_req ? head.wdata : 32'h0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= '{wr: wr, size: size, wstrb: wstrb,
                          addr: addr, wdata: wdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ISSUE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    data_ok = 1'b0;
    pop     = 1'b0;
    ld_cap  = 1'b0;
    unique case (state_q)
      ISSUE: begin
        mem_req = (cnt_q != '0);
        if (mem_req && mem_ack) begin
          ld_cap  = ~head.wr;
          state_d = RESP;
        end
      end
      RESP: begin
        data_ok = 1'b1;
        pop     = 1'b1;
        state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rdata_q <= 32'h0;
    else if (ld_cap) rdata_q <= mem_rdata;
  end

`ifdef DMEM_RESP_PERF_EN
  logic [31:0] perf_q;

  // Stall = work queued but nothing answered this cycle; saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= 32'h0;
    end else if (cnt_q != '0 && !data_ok && perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_req_responder.sv
// tb_dmem_req_responder: directed self-checking bench for
// dmem_req_responder (load, store, fill, wrap, reset, perf counter).
module tb_dmem_req_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] wdata = '0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] perf_cnt;

  int checks = 0;
  int errors = 0;

  dmem_req_responder #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr),
    .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    step();
    req = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last_rd;
  int          got;

  initial begin
    do_reset();
    chk("rst_addr_ok", {31'b0, addr_ok}, 32'd1);
    chk("rst_data_ok", {31'b0, data_ok}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_perf", perf_cnt, 32'h0);

    // single load, ack in the first mem_req cycle
    issue(1'b0, 32'h1003, 4'hF, 32'hFFFF_FFFF);
    chk("ld_mem_req", {31'b0, mem_req}, 32'd1);
    chk("ld_mem_addr", mem_addr, 32'h1000);
    chk("ld_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("ld_mem_we", {31'b0, mem_we}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hA1B2_C3D4;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("ld_data_ok", {31'b0, data_ok}, 32'd1);
    chk("ld_rdata", rdata, 32'hA1B2_C3D4);
    chk("ld_resp_mreq", {31'b0, mem_req}, 32'd0);
    step();
    chk("ld_data_ok_off", {31'b0, data_ok}, 32'd0);
    chk("ld_rdata_hold", rdata, 32'hA1B2_C3D4);

    // store
    issue(1'b1, 32'h2002, 4'b1100, 32'h5566_0000);
    chk("st_mem_we", {31'b0, mem_we}, 32'd1);
    chk("st_mem_wstrb", {28'b0, mem_wstrb}, 32'hC);
    chk("st_mem_addr", mem_addr, 32'h2000);
    chk("st_mem_wdata", mem_wdata, 32'h5566_0000);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    chk("st_data_ok", {31'b0, data_ok}, 32'd1);
    chk("st_rdata_keep", rdata, 32'hA1B2_C3D4);
    step();

    // fill with backend stalled
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_ok%0d", i), {31'b0, addr_ok}, 32'd1);
      req = 1'b1; wr = 1'b0; addr = 32'h100 + 32'(i * 4);
      step();
    end
    req = 1'b0;
    chk("fill_full", {31'b0, addr_ok}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_addr%0d", i), mem_addr, 32'h100 + 32'(i * 4));
      mem_ack = 1'b1; mem_rdata = 32'h11 * 32'(i + 1);
      step();
      mem_ack = 1'b0;
      chk($sformatf("fill_dok%0d", i), {31'b0, data_ok}, 32'd1);
      chk($sformatf("fill_rd%0d", i), rdata, 32'h11 * 32'(i + 1));
      if (i == 0) chk("fill_resp_full", {31'b0, addr_ok}, 32'd0);
      step();
      if (i == 0) chk("fill_reopen", {31'b0, addr_ok}, 32'd1);
    end
    last_rd = 32'h44;

    // wrap: alternating load/store, random ack delays
    got = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          exp_t e;
          bit acc;
          e.w = i[0];
          e.a = 32'h3000 + 32'(i * 4) + 32'(i % 4);
          e.s = 4'h1 << (i % 4);
          e.d = 32'hBEEF_0000 + 32'(i);
          req = 1'b1; wr = e.w; addr = e.a;
          wstrb = e.s; wdata = e.d;
          acc = 1'b0;
          for (int t = 0; t < 50 && !acc; t++) begin
            acc = addr_ok;
            if (acc) q.push_back(e);
            step();
          end
          if (!acc) chk("wrap_push_timeout", 32'd0, 32'd1);
        end
        req = 1'b0;
      end
      begin
        int d;
        d = -1;
        for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
          if (data_ok) begin
            if (q.size() == 0) begin
              chk("wrap_extra_resp", 32'd1, 32'd0);
            end else begin
              exp_t e;
              e = q.pop_front();
              if (!e.w) last_rd = 32'hC0DE_0000 | {16'h0, e.a[15:2], 2'b00};
              chk($sformatf("wrap_rd%0d", got), rdata, last_rd);
            end
            got++;
          end
          if (mem_req && d < 0) d = int'($urandom_range(0, 3));
          if (mem_req && d == 0 && q.size() != 0) begin
            chk("wrap_maddr", mem_addr, {q[0].a[31:2], 2'b00});
            chk("wrap_mwe", {31'b0, mem_we}, {31'b0, q[0].w});
            chk("wrap_mstrb", {28'b0, mem_wstrb},
                {28'b0, q[0].w ? q[0].s : 4'h0});
            mem_ack = 1'b1;
            mem_rdata = 32'hC0DE_0000 | {16'h0, mem_addr[15:0]};
          end else begin
            mem_ack = 1'b0;
          end
          if (d > 0) d--;
          step();
          if (mem_ack) begin
            mem_ack = 1'b0;
            d = -1;
          end
        end
      end
    join
    chk("wrap_count", 32'(got), 32'd10);
    chk("wrap_q_empty", 32'(q.size()), 32'd0);
    step();

    // reset with two loads queued and mem_req high
    issue(1'b0, 32'h500, 4'h0, 32'h0);
    issue(1'b0, 32'h504, 4'h0, 32'h0);
    chk("rm_mem_req_pre", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rm_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rm_data_ok", {31'b0, data_ok}, 32'd0);
    chk("rm_addr_ok", {31'b0, addr_ok}, 32'd1);
    chk("rm_rdata", rdata, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("rm_idle", {31'b0, mem_req}, 32'd0);
    issue(1'b0, 32'h4000, 4'h0, 32'h0);
    chk("rm_new_addr", mem_addr, 32'h4000);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    chk("rm_new_dok", {31'b0, data_ok}, 32'd1);
    chk("rm_new_rd", rdata, 32'h1234_5678);
    step();

    // stall counter
    do_reset();
    issue(1'b0, 32'h6000, 4'h0, 32'h0);
    repeat (3) step();
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 1'b0;
    chk("pf_dok", {31'b0, data_ok}, 32'd1);
`ifdef DMEM_RESP_PERF_EN
    chk("pf_cnt", perf_cnt, 32'd4);
    step();
    chk("pf_cnt_hold", perf_cnt, 32'd4);
`else
    chk("pf_cnt", perf_cnt, 32'd0);
    step();
    chk("pf_cnt_hold", perf_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
